uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
- UART transmitter: serializes one parallel byte into a frame of start bit, 8 data bits (LSB first), optional parity bit and stop bit.
- Runs on the same oversampled clock and PRESCALE value as the receive path. Each serial bit is held for PRESCALE CLK cycles, so TX and RX share one clock domain and one baud configuration.
- Sits between the system-side data source and the TX pad.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- PRESCALE_WIDTH, 6, width of PRESCALE and of the internal edge counter.

Ports:
- CLK  input  1  oversampled UART clock.
- RST  input  1  asynchronous, active-low reset.
- P_DATA  input  DATA_WIDTH  parallel byte to send.
- DATA_VALID  input  1  request to send P_DATA.
- PAR_EN  input  1  1 = append parity bit.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- PRESCALE  input  PRESCALE_WIDTH  CLK cycles per serial bit.
- TX_OUT  output  1  serial line, idle high, registered.
- BUSY  output  1  frame in progress, registered.

Behaviour:
- Reset (RST low, async): state IDLE, TX_OUT=1, BUSY=0, edge_cnt=0, bit_cnt=0, all capture registers cleared. Reset asserted mid-frame aborts the frame and forces TX_OUT=1 immediately.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Accept: in IDLE with DATA_VALID=1, on the next CLK edge:
  - capture P_DATA, PAR_EN, PAR_TYP and PRESCALE;
  - enter START;
  - set TX_OUT=0 and BUSY=1.
  - Latency from accept to start bit on the line: 1 cycle.
- DATA_VALID outside IDLE is ignored. There is no queue; the data is not held for later.
- Input changes after accept have no effect on the current frame.
- Bit timing:
  - edge_cnt counts 0..PRESCALE-1 in every non-IDLE state.
  - When edge_cnt == PRESCALE-1 (PRESCALE_WIDTH-bit arithmetic), edge_cnt wraps to 0 and the bit ends.
  - PRESCALE=0 therefore yields 64 cycles per bit (6-bit wrap). PRESCALE=1 yields 1 cycle per bit.
- Transitions at each bit end:
  - START -> DATA, bit_cnt=0.
  - DATA: TX_OUT = data[bit_cnt]. bit_cnt increments at each bit end. After bit DATA_WIDTH-1 -> PARITY if captured PAR_EN=1, else STOP.
  - PARITY: TX_OUT = XOR of all captured data bits, XOR PAR_TYP. Then -> STOP.
  - STOP: TX_OUT=1. At bit end -> IDLE and BUSY=0.
- TX_OUT is updated on the same edge that enters each state or bit, so every bit occupies exactly PRESCALE cycles on the line.
- Frame length = (1 + DATA_WIDTH + PAR_EN + 1) x PRESCALE cycles.
- BUSY is high for exactly the frame length.
- Back-to-back frames: at least one IDLE cycle (TX_OUT=1, BUSY=0) separates frames. A DATA_VALID held high is accepted in that IDLE cycle.
- edge_cnt and bit_cnt hold 0 while in IDLE.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN.
- Defined: the STOP state lasts 2 x PRESCALE cycles (two stop bits), and the frame length grows by PRESCALE.
- Undefined: a single stop bit, as described under Behaviour.
- Start, data and parity timing are identical in both builds.

Test Plan:
- Reset: hold RST low, toggle CLK, pulse DATA_VALID -> TX_OUT=1, BUSY=0 throughout. Release RST -> still idle until DATA_VALID.
- Basic frame: PRESCALE=8, PAR_EN=0, P_DATA=0xA5, DATA_VALID for 1 cycle -> TX_OUT = 0,1,0,1,0,0,1,0,1,1, each bit 8 cycles. BUSY high for 80 cycles, low on cycle 81.
- Parity: P_DATA=0xA5 with PAR_EN=1 -> parity bit 0 when PAR_TYP=0, 1 when PAR_TYP=1. Frame length 88 cycles at PRESCALE=8.
- Ignore while busy: mid-frame, assert DATA_VALID with P_DATA=0x3C -> the 0xA5 frame completes unchanged and 0x3C is not sent unless DATA_VALID is still high in IDLE. DATA_VALID held high -> 1-cycle idle gap, then the 0x3C frame.
- Prescale corners: PRESCALE=1, P_DATA=0xFF -> 10-cycle frame. PRESCALE=0 -> 64 cycles per bit. Changing PRESCALE mid-frame has no effect.
- Reset mid-frame: assert RST during the DATA bit 3 window -> TX_OUT=1 and BUSY=0 asynchronously. After release, the next DATA_VALID starts a clean frame. With UART_TX_TWO_STOP_EN, the basic frame is 88 cycles with 16 stop-high cycles.

Source files
------------

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
//   UART transmitter: serializes one parallel word into a frame of
//   start bit, DATA_WIDTH data bits (LSB first), optional parity bit and
//   stop bit. Each serial bit is held for PRESCALE CLK cycles; a PRESCALE
//   of 0 wraps the PRESCALE_WIDTH-bit edge counter and gives
//   2**PRESCALE_WIDTH cycles per bit.
//
//   Compile-time option:
//     UART_TX_TWO_STOP_EN  - when defined, the stop phase lasts two bit
//                            times (two stop bits); otherwise one.
//
//   All request-side inputs are captured at accept, so later changes on
//   P_DATA / PAR_EN / PAR_TYP / PRESCALE never disturb a frame in flight.
//   DATA_VALID outside IDLE is ignored; there is no queue.
// -----------------------------------------------------------------------------
module uart_tx_frame #(
   parameter int DATA_WIDTH     = 8,
   parameter int PRESCALE_WIDTH = 6
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [DATA_WIDTH-1:0]     P_DATA,
   input  logic                      DATA_VALID,
   input  logic                      PAR_EN,
   input  logic                      PAR_TYP,
   input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
   output logic                      TX_OUT,
   output logic                      BUSY
);

   localparam int BIT_CNT_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BIT_CNT_WIDTH-1:0] LAST_DATA_BIT = BIT_CNT_WIDTH'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                       state_q;
   logic [PRESCALE_WIDTH-1:0]    edge_cnt_q;
   logic [BIT_CNT_WIDTH-1:0]     bit_cnt_q;
   logic [DATA_WIDTH-1:0]        shift_q;      // data still to be sent, LSB next
   logic                         par_en_q;
   logic                         parity_q;     // parity bit value, fixed at accept
   logic [PRESCALE_WIDTH-1:0]    prescale_q;
   logic                         tx_out_q;
   logic                         busy_q;
`ifdef UART_TX_TWO_STOP_EN
   logic                         stop_second_q; // second stop bit in progress
`endif

   logic [PRESCALE_WIDTH-1:0]    edge_last_d;
   logic                         bit_end_d;

   // Bit-end detect: last cycle of the current bit, in PRESCALE_WIDTH-bit
   // arithmetic so PRESCALE=0 naturally yields a full-range bit time.
   // NOTE: every signal assigned in a combinational block gets a value on
   // every path, otherwise synthesis infers a latch.
   always_comb begin
      edge_last_d = prescale_q - PRESCALE_WIDTH'(1);
      bit_end_d   = (edge_cnt_q == edge_last_d);
   end

   // Frame FSM with registered TX_OUT / BUSY; each output is updated on the
   // same edge that enters a state or bit, so every bit is exactly
   // PRESCALE cycles wide on the line.
   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together from pre-edge values, independent of statement order.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q       <= S_IDLE;
         edge_cnt_q    <= '0;
         bit_cnt_q     <= '0;
         shift_q       <= '0;
         par_en_q      <= 1'b0;
         parity_q      <= 1'b0;
         prescale_q    <= '0;
         tx_out_q      <= 1'b1;
         busy_q        <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
         stop_second_q <= 1'b0;
`endif
      end else begin
         // Edge counter runs in every non-idle state and rests at 0 in IDLE.
         if (state_q == S_IDLE || bit_end_d) begin
            edge_cnt_q <= '0;
         end else begin
            edge_cnt_q <= edge_cnt_q + PRESCALE_WIDTH'(1);
         end

         unique case (state_q)
            S_IDLE: begin
               bit_cnt_q <= '0;
               tx_out_q  <= 1'b1;
               busy_q    <= 1'b0;
               if (DATA_VALID) begin
                  shift_q    <= P_DATA;
                  par_en_q   <= PAR_EN;
                  parity_q   <= (^P_DATA) ^ PAR_TYP;
                  prescale_q <= PRESCALE;
                  tx_out_q   <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= S_START;
`ifdef UART_TX_TWO_STOP_EN
                  stop_second_q <= 1'b0;
`endif
               end
            end

            S_START: begin
               if (bit_end_d) begin
                  bit_cnt_q <= '0;
                  tx_out_q  <= shift_q[0];
                  shift_q   <= shift_q >> 1;
                  state_q   <= S_DATA;
               end
            end

            S_DATA: begin
               if (bit_end_d) begin
                  if (bit_cnt_q == LAST_DATA_BIT) begin
                     bit_cnt_q <= '0;
                     if (par_en_q) begin
                        tx_out_q <= parity_q;
                        state_q  <= S_PARITY;
                     end else begin
                        tx_out_q <= 1'b1;
                        state_q  <= S_STOP;
                     end
                  end else begin
                     bit_cnt_q <= bit_cnt_q + BIT_CNT_WIDTH'(1);
                     tx_out_q  <= shift_q[0];
                     shift_q   <= shift_q >> 1;
                  end
               end
            end

            S_PARITY: begin
               if (bit_end_d) begin
                  tx_out_q <= 1'b1;
                  state_q  <= S_STOP;
               end
            end

            S_STOP: begin
               if (bit_end_d) begin
`ifdef UART_TX_TWO_STOP_EN
                  if (!stop_second_q) begin
                     stop_second_q <= 1'b1;
                  end else begin
                     stop_second_q <= 1'b0;
                     busy_q        <= 1'b0;
                     state_q       <= S_IDLE;
                  end
`else
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
`endif
               end
            end

            default: begin
               tx_out_q <= 1'b1;
               busy_q   <= 1'b0;
               state_q  <= S_IDLE;
            end
         endcase
      end
   end

   assign TX_OUT = tx_out_q;
   assign BUSY   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_frame
//   Self-checking bench for uart_tx_frame. The reference model describes a
//   frame as a list of bit values, each stretched to its bit time, and
//   predicts TX_OUT/BUSY cycle by cycle from that. Inputs are driven on the
//   falling edge; outputs are sampled on the falling edge.
//   Honours UART_TX_TWO_STOP_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_uart_tx_frame;

   localparam int DW = 8;
   localparam int PW = 6;
`ifdef UART_TX_TWO_STOP_EN
   localparam int N_STOP = 2;
`else
   localparam int N_STOP = 1;
`endif

   logic          CLK;
   logic          RST;
   logic [DW-1:0] P_DATA;
   logic          DATA_VALID;
   logic          PAR_EN;
   logic          PAR_TYP;
   logic [PW-1:0] PRESCALE;
   logic          TX_OUT;
   logic          BUSY;

   int vectors;
   int miscompares;

   uart_tx_frame #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .P_DATA     (P_DATA),
      .DATA_VALID (DATA_VALID),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .PRESCALE   (PRESCALE),
      .TX_OUT     (TX_OUT),
      .BUSY       (BUSY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // ---------------- reference model ----------------
   function automatic int bit_cycles(input logic [PW-1:0] ps);
      return (ps == 0) ? (1 << PW) : int'(ps);
   endfunction

   function automatic int frame_len(input logic pe, input logic [PW-1:0] ps);
      return (1 + DW + int'(pe) + N_STOP) * bit_cycles(ps);
   endfunction

   // Expected line level k cycles (0-based) after the accepting edge.
   function automatic logic exp_tx(input logic [DW-1:0] d, input logic pe,
                                   input logic pt, input logic [PW-1:0] ps,
                                   input int k);
      int idx;
      idx = k / bit_cycles(ps);
      if (idx == 0) return 1'b0;
      if (idx <= DW) return d[idx-1];
      if (pe && idx == DW + 1) begin
         logic p;
         p = pt;
         for (int i = 0; i < DW; i++) p = p ^ d[i];
         return p;
      end
      return 1'b1;
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      RST = 1'b0; DATA_VALID = 1'b0; P_DATA = 8'h00; PAR_EN = 1'b0;
      PAR_TYP = 1'b0; PRESCALE = 6'd8;
      for (int c = 0; c < 6; c++) begin
         @(negedge CLK);
         DATA_VALID = (c == 2);
         P_DATA     = 8'h5A;
         vectors++;
         if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold cyc %0d: TX_OUT=%b BUSY=%b want 1/0", c, TX_OUT, BUSY);
         end
      end
      DATA_VALID = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge CLK);
         vectors++;
         if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release cyc %0d: TX_OUT=%b BUSY=%b want 1/0", c, TX_OUT, BUSY);
         end
      end
   endtask

   // One frame; optionally scramble all request inputs right after accept
   // (they must have no effect on the frame in flight).
   task automatic test_frame(input string name, input logic [DW-1:0] d,
                             input logic pe, input logic pt,
                             input logic [PW-1:0] ps, input bit scramble);
      int len;
      logic e;
      len = frame_len(pe, ps);
      @(negedge CLK);
      P_DATA = d; PAR_EN = pe; PAR_TYP = pt; PRESCALE = ps; DATA_VALID = 1'b1;
      @(negedge CLK);
      DATA_VALID = 1'b0;
      for (int k = 0; k < len; k++) begin
         if (scramble && k == 2) begin
            P_DATA = DW'($urandom); PAR_EN = ~pe; PAR_TYP = ~pt;
            PRESCALE = PW'($urandom_range(1, 5));
         end
         e = exp_tx(d, pe, pt, ps, k);
         vectors++;
         if (TX_OUT !== e || BUSY !== 1'b1) begin
            miscompares++;
            $display("FAIL %s cyc %0d: TX_OUT=%b BUSY=%b want %b/1", name, k, TX_OUT, BUSY, e);
         end
         @(negedge CLK);
      end
      vectors++;
      if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
         miscompares++;
         $display("FAIL %s end: TX_OUT=%b BUSY=%b want 1/0", name, TX_OUT, BUSY);
      end
   endtask

   // DATA_VALID raised mid-frame with new data and held: current frame must
   // finish unchanged, one idle cycle, then the new frame.
   task automatic test_ignore_busy();
      int len;
      logic e;
      len = frame_len(1'b0, 6'd8);
      @(negedge CLK);
      P_DATA = 8'hA5; PAR_EN = 1'b0; PAR_TYP = 1'b0; PRESCALE = 6'd8; DATA_VALID = 1'b1;
      @(negedge CLK);
      DATA_VALID = 1'b0;
      for (int k = 0; k < len; k++) begin
         if (k == 20) begin
            P_DATA = 8'h3C; DATA_VALID = 1'b1;
         end
         e = exp_tx(8'hA5, 1'b0, 1'b0, 6'd8, k);
         vectors++;
         if (TX_OUT !== e || BUSY !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_first cyc %0d: TX_OUT=%b BUSY=%b want %b/1", k, TX_OUT, BUSY, e);
         end
         @(negedge CLK);
      end
      vectors++;
      if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
         miscompares++;
         $display("FAIL busy_gap: TX_OUT=%b BUSY=%b want 1/0", TX_OUT, BUSY);
      end
      @(negedge CLK);
      DATA_VALID = 1'b0;
      for (int k = 0; k < len; k++) begin
         e = exp_tx(8'h3C, 1'b0, 1'b0, 6'd8, k);
         vectors++;
         if (TX_OUT !== e || BUSY !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_second cyc %0d: TX_OUT=%b BUSY=%b want %b/1", k, TX_OUT, BUSY, e);
         end
         @(negedge CLK);
      end
      vectors++;
      if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
         miscompares++;
         $display("FAIL busy_second end: TX_OUT=%b BUSY=%b want 1/0", TX_OUT, BUSY);
      end
   endtask

   // Reset asserted inside data bit 3: line must go idle at once.
   task automatic test_reset_mid();
      logic e;
      @(negedge CLK);
      P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b1; PRESCALE = 6'd8; DATA_VALID = 1'b1;
      @(negedge CLK);
      DATA_VALID = 1'b0;
      for (int k = 0; k < 35; k++) begin
         e = exp_tx(8'hA5, 1'b1, 1'b1, 6'd8, k);
         vectors++;
         if (TX_OUT !== e || BUSY !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid pre cyc %0d: TX_OUT=%b BUSY=%b want %b/1", k, TX_OUT, BUSY, e);
         end
         @(negedge CLK);
      end
      #1 RST = 1'b0;
      #1;
      vectors++;
      if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_mid async: TX_OUT=%b BUSY=%b want 1/0", TX_OUT, BUSY);
      end
      repeat (3) @(negedge CLK);
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      vectors++;
      if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_mid after: TX_OUT=%b BUSY=%b want 1/0", TX_OUT, BUSY);
      end
      test_frame("rst_mid_clean", 8'h96, 1'b0, 1'b0, 6'd4, 1'b0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 20; n++) begin
         test_frame("random", DW'($urandom), 1'($urandom), 1'($urandom),
                    PW'($urandom_range(1, 12)), 1'b1);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_frame("basic", 8'hA5, 1'b0, 1'b0, 6'd8, 1'b0);
      test_frame("parity_even", 8'hA5, 1'b1, 1'b0, 6'd8, 1'b0);
      test_frame("parity_odd", 8'hA5, 1'b1, 1'b1, 6'd8, 1'b0);
      test_frame("parity_odd_b", 8'h07, 1'b1, 1'b1, 6'd3, 1'b0);
      test_ignore_busy();
      test_frame("prescale1", 8'hFF, 1'b0, 1'b0, 6'd1, 1'b0);
      test_frame("prescale0", 8'h4D, 1'b1, 1'b0, 6'd0, 1'b0);
      test_frame("prescale_change", 8'hC3, 1'b0, 1'b0, 6'd7, 1'b1);
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
